// File: rtl/div_sgn_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Build option: DIV_SGN_SEQ_EARLY_OUT_EN (consumed by div_sgn_seq).
package div_sgn_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Width of an iteration counter that must hold n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Two's complement negation when neg is set; callers widen to 64 bits and truncate back.
    function automatic logic [63:0] negate_if(input logic [63:0] x, input logic neg);
        return neg ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/div_sgn_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit, subtract if it fits.
module div_sgn_step #(
    parameter int widthD = 8
) (
    input  logic [widthD-1:0] i_rem,
    input  logic [widthD-1:0] i_dMag,
    input  logic              i_bit,
    output logic [widthD-1:0] o_rem,
    output logic              o_qBit
);

    logic [widthD:0] w_shift;

    // The incoming remainder is always below |D|, so the shifted value needs only one extra bit.
    assign w_shift = {i_rem, i_bit};
    assign o_qBit  = (w_shift >= {1'b0, i_dMag});
    assign o_rem   = o_qBit ? widthD'(w_shift - {1'b0, i_dMag}) : w_shift[widthD-1:0];

endmodule

// File: rtl/div_sgn_seq.sv
// Sequential signed divider, one quotient bit per cycle, valid/ready on both sides.
// Build option: DIV_SGN_SEQ_EARLY_OUT_EN skips iteration for dz, ovf and |N| < |D|.
module div_sgn_seq
    import div_sgn_pkg::*;
#(
    parameter int widthN = 16,
    parameter int widthD = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [widthN-1:0] N_i,
    input  logic [widthD-1:0] D_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [widthN-1:0] Q_o,
    output logic [widthD-1:0] R_o,
    output logic              dz_o,
    output logic              ovf_o
);

    localparam int CW = cnt_w(widthN);

    state_e            r_state;
    logic [widthN-1:0] r_n;
    logic [widthD-1:0] r_d;
    logic [widthN-1:0] r_nMag;
    logic [widthD-1:0] r_dMag;
    logic [widthD-1:0] r_rem;
    logic [CW-1:0]     r_cnt;
    logic              r_dz;
    logic              r_ovf;
    logic              r_inReady;
    logic              r_outValid;
    logic [widthN-1:0] r_qOut;
    logic [widthD-1:0] r_rOut;
    logic              r_dzOut;
    logic              r_ovfOut;

    logic [widthN-1:0] w_nMag;
    logic [widthD-1:0] w_dMag;
    logic              w_dz;
    logic              w_ovf;
    logic [widthD-1:0] w_stepRem;
    logic              w_qBit;
    logic [widthN-1:0] w_qSigned;
    logic [widthD-1:0] w_rSigned;

    // Magnitude of the most-negative N wraps to itself, which is exact as an unsigned value.
    assign w_nMag    = widthN'(negate_if(64'(r_n), r_n[widthN-1]));
    assign w_dMag    = widthD'(negate_if(64'(r_d), r_d[widthD-1]));
    assign w_dz      = (r_d == '0);
    assign w_ovf     = (r_n == {1'b1, {(widthN-1){1'b0}}}) && (r_d == '1);
    assign w_qSigned = widthN'(negate_if(64'(r_nMag), r_n[widthN-1] ^ r_d[widthD-1]));
    assign w_rSigned = widthD'(negate_if(64'(r_rem), r_n[widthN-1]));

`ifdef DIV_SGN_SEQ_EARLY_OUT_EN
    logic w_small;
    assign w_small = (widthN'(w_dMag) > w_nMag);
`endif

    div_sgn_step #(
        .widthD (widthD)
    ) u_step (
        .i_rem  (r_rem),
        .i_dMag (r_dMag),
        .i_bit  (r_nMag[widthN-1]),
        .o_rem  (w_stepRem),
        .o_qBit (w_qBit)
    );

    // r_nMag doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_n        <= '0;
            r_d        <= '0;
            r_nMag     <= '0;
            r_dMag     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_qOut     <= '0;
            r_rOut     <= '0;
            r_dzOut    <= 1'b0;
            r_ovfOut   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_n       <= N_i;
                        r_d       <= D_i;
                        r_inReady <= 1'b0;
                        r_state   <= PREP;
                    end
                end
                PREP: begin
                    r_nMag <= w_nMag;
                    r_dMag <= w_dMag;
                    r_rem  <= '0;
                    r_dz   <= w_dz;
                    r_ovf  <= w_ovf;
                    r_cnt  <= CW'(widthN - 1);
`ifdef DIV_SGN_SEQ_EARLY_OUT_EN
                    if (w_dz || w_ovf || w_small) begin
                        r_nMag  <= '0;
                        r_rem   <= w_nMag[widthD-1:0];
                        r_state <= FIX;
                    end else begin
                        r_state <= ITER;
                    end
`else
                    r_state <= ITER;
`endif
                end
                ITER: begin
                    r_rem  <= w_stepRem;
                    r_nMag <= {r_nMag[widthN-2:0], w_qBit};
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (r_dz) begin
                        r_qOut <= '1;
                        r_rOut <= r_n[widthD-1:0];
                    end else if (r_ovf) begin
                        r_qOut <= r_n;
                        r_rOut <= '0;
                    end else begin
                        r_qOut <= w_qSigned;
                        r_rOut <= w_rSigned;
                    end
                    r_dzOut    <= r_dz;
                    r_ovfOut   <= r_ovf;
                    r_outValid <= 1'b1;
                    r_state    <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = r_inReady;
    assign out_valid_o = r_outValid;
    assign Q_o         = r_qOut;
    assign R_o         = r_rOut;
    assign dz_o        = r_dzOut;
    assign ovf_o       = r_ovfOut;

endmodule

// File: tb/tb_div_sgn_seq.sv
// Self-checking bench for div_sgn_seq (widthN=16, widthD=8, default build) against an integer-arithmetic model.
module tb_div_sgn_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] N_i;
    logic [7:0]  D_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] Q_o;
    logic [7:0]  R_o;
    logic        dz_o;
    logic        ovf_o;

    int passCount  = 0;
    int checkCount = 0;

    div_sgn_seq #(
        .widthN (16),
        .widthD (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .N_i         (N_i),
        .D_i         (D_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .Q_o         (Q_o),
        .R_o         (R_o),
        .dz_o        (dz_o),
        .ovf_o       (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: SV integer / and % truncate toward zero with remainder taking the dividend's sign.
    function automatic logic [25:0] model(input logic [15:0] n, input logic [7:0] d);
        int ni;
        int di;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        logic        ovf;
        ni  = $signed(n);
        di  = $signed(d);
        dz  = (di == 0);
        ovf = (ni == -32768) && (di == -1);
        if (dz) begin
            q = 16'hFFFF;
            r = n[7:0];
        end else if (ovf) begin
            q = 16'h8000;
            r = 8'h00;
        end else begin
            q = 16'(ni / di);
            r = 8'(ni % di);
        end
        return {q, r, dz, ovf};
    endfunction

    // Waits for in_ready, presents operands for one accept edge, then scrambles the inputs.
    task automatic send(input logic [15:0] n, input logic [7:0] d);
        int guard = 0;
        while (!in_ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        N_i        = n;
        D_i        = d;
        in_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        N_i        = 16'($urandom);
        D_i        = 8'($urandom);
    endtask

    // Counts accept-relative edges until out_valid_o is seen; gives up after 200.
    task automatic waitValid(output int cyc);
        cyc = 0;
        while (!out_valid_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        N_i         = '0;
        D_i         = '0;
        repeat (2) @(negedge clk);
        checkCount++;
        if (in_ready_o !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready_o);
        else passCount++;
        checkCount++;
        if (out_valid_o !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid_o);
        else passCount++;
        checkCount++;
        if ({Q_o, R_o, dz_o, ovf_o} !== 26'd0)
            $display("[TB] FAIL reset_outputs: got Q=%h R=%h dz=%b ovf=%b expected all zero", Q_o, R_o, dz_o, ovf_o);
        else passCount++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int          dirN [10] = '{100, -100, 100, -32768, 1234, 9, 32767, -32768, -32768, -7};
        int          dirD [10] = '{7, 7, -7, -1, 0, 3, -128, 1, -128, 7};
        logic [25:0] exp;
        int          cyc;
        for (int i = 0; i < 10; i++) begin
            send(16'(dirN[i]), 8'(dirD[i]));
            waitValid(cyc);
            exp = model(16'(dirN[i]), 8'(dirD[i]));
            checkCount++;
            if (cyc !== 18) $display("[TB] FAIL directed_latency[%0d]: got %0d expected 18", i, cyc);
            else passCount++;
            checkCount++;
            if ({Q_o, R_o, dz_o, ovf_o} !== exp)
                $display("[TB] FAIL directed_result[%0d]: got Q=%h R=%h dz=%b ovf=%b expected Q=%h R=%h dz=%b ovf=%b",
                         i, Q_o, R_o, dz_o, ovf_o, exp[25:10], exp[9:2], exp[1], exp[0]);
            else passCount++;
            out_ready_i = 1'b1;
            @(negedge clk);
            out_ready_i = 1'b0;
            checkCount++;
            if ({out_valid_o, in_ready_o} !== 2'b01)
                $display("[TB] FAIL directed_handshake[%0d]: got valid=%b ready=%b expected valid=0 ready=1",
                         i, out_valid_o, in_ready_o);
            else passCount++;
        end
    endtask

    task automatic test_stall();
        logic [25:0] exp;
        int          cyc;
        send(16'd100, 8'd7);
        waitValid(cyc);
        exp = model(16'd100, 8'd7);
        for (int k = 0; k < 5; k++) begin
            checkCount++;
            if ({out_valid_o, in_ready_o, Q_o, R_o, dz_o, ovf_o} !== {2'b10, exp})
                $display("[TB] FAIL stall_hold[%0d]: got valid=%b ready=%b Q=%h R=%h expected valid=1 ready=0 Q=%h R=%h",
                         k, out_valid_o, in_ready_o, Q_o, R_o, exp[25:10], exp[9:2]);
            else passCount++;
            in_valid_i = 1'b1;
            N_i        = 16'hBEEF;
            D_i        = 8'h05;
            @(negedge clk);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        send(16'hFF9C, 8'd7);
        waitValid(cyc);
        exp = model(16'hFF9C, 8'd7);
        checkCount++;
        if ({Q_o, R_o, dz_o, ovf_o} !== exp)
            $display("[TB] FAIL stall_next_op: got Q=%h R=%h expected Q=%h R=%h", Q_o, R_o, exp[25:10], exp[9:2]);
        else passCount++;
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [25:0] exp;
        int          cyc;
        send(16'd30000, 8'd77);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkCount++;
        if ({out_valid_o, in_ready_o, Q_o, R_o, dz_o, ovf_o} !== {2'b01, 26'd0})
            $display("[TB] FAIL reset_mid_async: got valid=%b ready=%b Q=%h R=%h dz=%b ovf=%b expected ready=1 rest zero",
                     out_valid_o, in_ready_o, Q_o, R_o, dz_o, ovf_o);
        else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(16'd9, 8'd3);
        waitValid(cyc);
        exp = model(16'd9, 8'd3);
        checkCount++;
        if ({cyc, Q_o, R_o, dz_o, ovf_o} !== {32'(18), exp})
            $display("[TB] FAIL reset_mid_next_op: got lat=%0d Q=%h R=%h expected lat=18 Q=%h R=%h",
                     cyc, Q_o, R_o, exp[25:10], exp[9:2]);
        else passCount++;
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] n;
        logic [7:0]  d;
        logic [25:0] exp;
        int          cyc;
        for (int i = 0; i < 40; i++) begin
            n = 16'($urandom);
            d = 8'($urandom);
            if (i % 10 == 3) d = 8'h00;
            if (i % 10 == 5) begin n = 16'h8000; d = 8'hFF; end
            if (i % 10 == 7) d = 8'hFF;
            send(n, d);
            waitValid(cyc);
            exp = model(n, d);
            checkCount++;
            if ({cyc, Q_o, R_o, dz_o, ovf_o} !== {32'(18), exp})
                $display("[TB] FAIL random[%0d] N=%h D=%h: got lat=%0d Q=%h R=%h dz=%b ovf=%b expected lat=18 Q=%h R=%h dz=%b ovf=%b",
                         i, n, d, cyc, Q_o, R_o, dz_o, ovf_o, exp[25:10], exp[9:2], exp[1], exp[0]);
            else passCount++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            out_ready_i = 1'b1;
            @(negedge clk);
            out_ready_i = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] n;
        logic [7:0]  d;
        logic [25:0] exp;
        int          cyc;
        out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n = 16'($urandom);
            d = 8'($urandom_range(1, 255));
            send(n, d);
            waitValid(cyc);
            exp = model(n, d);
            checkCount++;
            if ({cyc, Q_o, R_o, dz_o, ovf_o} !== {32'(18), exp})
                $display("[TB] FAIL b2b_result[%0d]: got lat=%0d Q=%h R=%h expected lat=18 Q=%h R=%h",
                         i, cyc, Q_o, R_o, exp[25:10], exp[9:2]);
            else passCount++;
            @(negedge clk);
            checkCount++;
            if ({out_valid_o, in_ready_o} !== 2'b01)
                $display("[TB] FAIL b2b_single_cycle[%0d]: got valid=%b ready=%b expected valid=0 ready=1",
                         i, out_valid_o, in_ready_o);
            else passCount++;
        end
        out_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
